// File: rtl/plic_agent_pkg.sv
// Shared types and address helpers for the PLIC claim/complete agent.
package plic_agent_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLAIM     = 3'd1,
    DISPATCH  = 3'd2,
    WAIT_DONE = 3'd3,
    COMPLETE  = 3'd4,
    HOLDOFF   = 3'd5
  } state_e;

  localparam logic [31:0] CC_OFFSET  = 32'h0020_0004;
  localparam logic [31:0] CTX_STRIDE = 32'h0000_1000;

  function automatic logic [31:0] cc_addr(input logic [31:0] base, input logic [31:0] target);
    return base + CC_OFFSET + (target * CTX_STRIDE);
  endfunction

endpackage

// File: rtl/reg_intf.sv
// Register-interface bus types shared between initiators and the PLIC register map.
package reg_intf;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_intf_req_a32_d32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_intf_resp_d32;

endpackage

// File: rtl/plic_claim_agent.sv
// Hart-side PLIC agent: claims an ID, hands it to a handler, then writes it back to complete.
// Optional claim/spurious statistics counters are built when PLIC_CLAIM_STATS_EN is defined.
import plic_agent_pkg::*;

module plic_claim_agent #(
  parameter int          N_SOURCE       = 30,
  parameter int          SRCW           = $clog2(N_SOURCE + 1),
  parameter int          TARGET_ID      = 0,
  parameter logic [31:0] PLIC_BASE      = 32'h0C00_0000,
  parameter int          HOLDOFF_CYCLES = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  output reg_intf::reg_intf_req_a32_d32  req_o,
  input  reg_intf::reg_intf_resp_d32     resp_i,
  input  logic                           eip_i,
  input  logic                           enable_i,
  output logic                           irq_valid_o,
  input  logic                           irq_ready_i,
  output logic [SRCW-1:0]                irq_id_o,
  input  logic                           done_i,
  output logic                           spurious_o,
  output logic                           bus_err_o,
`ifdef PLIC_CLAIM_STATS_EN
  output logic [31:0]                    claim_cnt_o,
  output logic [31:0]                    spurious_cnt_o,
`endif
  output logic                           busy_o
);

  localparam logic [31:0]  CC_ADDR   = cc_addr(PLIC_BASE, 32'(TARGET_ID));
  localparam int           HCW       = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLDOFF_CYCLES - 1);

  state_e                      state_r, state_s;
  logic [SRCW-1:0]             id_r, id_s;
  logic [HCW-1:0]              hold_r, hold_s;
  reg_intf::reg_intf_req_a32_d32 req_r, req_s;
  logic                        irq_valid_r, spur_r, spur_s, berr_r, berr_s, busy_r;
  logic                        id_ok_s;

  // Next-state, latched ID, holdoff counter and next bus request.
  always_comb begin
    state_s = state_r;
    id_s    = id_r;
    hold_s  = hold_r;
    spur_s  = 1'b0;
    berr_s  = 1'b0;
    id_ok_s = (resp_i.rdata != 32'd0) && (resp_i.rdata <= 32'(N_SOURCE));
    case (state_r)
      IDLE: begin
        if (eip_i && enable_i) state_s = CLAIM;
        else                   state_s = IDLE;
      end
      CLAIM: begin
        if (resp_i.ready) begin
          if (resp_i.error) begin
            berr_s  = 1'b1;
            state_s = HOLDOFF;
            hold_s  = HOLD_LOAD;
          end else if (!id_ok_s) begin
            spur_s  = 1'b1;
            state_s = HOLDOFF;
            hold_s  = HOLD_LOAD;
          end else begin
            id_s    = resp_i.rdata[SRCW-1:0];
            state_s = DISPATCH;
          end
        end else begin
          state_s = CLAIM;
        end
      end
      DISPATCH: begin
        if (irq_ready_i) state_s = WAIT_DONE;
        else             state_s = DISPATCH;
      end
      WAIT_DONE: begin
        if (done_i) state_s = COMPLETE;
        else        state_s = WAIT_DONE;
      end
      COMPLETE: begin
        if (resp_i.ready) begin
          berr_s  = resp_i.error;
          state_s = HOLDOFF;
          hold_s  = HOLD_LOAD;
        end else begin
          state_s = COMPLETE;
        end
      end
      HOLDOFF: begin
        if (hold_r == {HCW{1'b0}}) state_s = IDLE;
        else                       hold_s  = hold_r - HCW'(1);
      end
      default: state_s = IDLE;
    endcase

    // Request is a pure function of the next state, so it stays stable while waiting.
    req_s.valid = (state_s == CLAIM) || (state_s == COMPLETE);
    req_s.write = (state_s == COMPLETE);
    req_s.addr  = req_s.valid ? CC_ADDR : 32'd0;
    req_s.wdata = (state_s == COMPLETE) ? {{(32-SRCW){1'b0}}, id_s} : 32'd0;
    req_s.wstrb = (state_s == COMPLETE) ? 4'hF : 4'h0;
  end

  // State, ID, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      id_r        <= {SRCW{1'b0}};
      hold_r      <= {HCW{1'b0}};
      req_r       <= '0;
      irq_valid_r <= 1'b0;
      spur_r      <= 1'b0;
      berr_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      id_r        <= id_s;
      hold_r      <= hold_s;
      req_r       <= req_s;
      irq_valid_r <= (state_s == DISPATCH);
      spur_r      <= spur_s;
      berr_r      <= berr_s;
      busy_r      <= (state_s != IDLE);
    end
  end

`ifdef PLIC_CLAIM_STATS_EN
  logic [31:0] claim_cnt_r, spurious_cnt_r;

  // Successful and spurious claim counters; bus errors count in neither.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      claim_cnt_r    <= 32'd0;
      spurious_cnt_r <= 32'd0;
    end else begin
      if ((state_r == CLAIM) && (state_s == DISPATCH)) claim_cnt_r <= claim_cnt_r + 32'd1;
      if (spur_s) spurious_cnt_r <= spurious_cnt_r + 32'd1;
    end
  end

  assign claim_cnt_o    = claim_cnt_r;
  assign spurious_cnt_o = spurious_cnt_r;
`endif

  assign req_o       = req_r;
  assign irq_valid_o = irq_valid_r;
  assign irq_id_o    = id_r;
  assign spurious_o  = spur_r;
  assign bus_err_o   = berr_r;
  assign busy_o      = busy_r;

endmodule
